// File: rtl/wb_master_sequencer.sv
// wb_master_sequencer
// Wishbone classic initiator. It takes one register-access command at a time
// and runs one Wishbone cycle for it. Every cycle is bounded by an ACK
// timeout. The result (read data or a timeout error) comes back on a
// valid/ready response port.
//
// Ports:
//   WBs_CLK_i, WBs_RST_n_i        clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i,          command: direction, word address,
//   cmd_byte_stb_i, cmd_dat_i     byte enables, write data
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_dat_o, rsp_err_o          read data (0 for writes/errors), timeout flag
//   WBm_*                         Wishbone master bus
//   busy_o                        high whenever a command is in flight
//   err_cnt_o                     saturating count of timeouts
module wb_master_sequencer #(
  parameter int ADDRWIDTH      = 7,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_byte_stb_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic                 busy_o,
  output logic [7:0]           err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  logic [CNTW-1:0]        tmo_cnt_q;
  logic [ADDRWIDTH-1:0]   adr_q;
  logic                   cyc_q;
  logic                   we_q;
  logic [3:0]             bstb_q;
  logic [DATAWIDTH-1:0]   wdat_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [DATAWIDTH-1:0]   rsp_dat_q;
  logic [7:0]             err_cnt_q;
  logic                   tmo_hit_d;

  assign tmo_hit_d = (tmo_cnt_q == TMO_LAST);

  // Sequencer FSM. All bus and response outputs are registered here.
  // In BUS, ACK is tested before the timeout. An ACK seen on the last
  // allowed cycle therefore still completes as a success.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      bstb_q      <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            adr_q     <= cmd_adr_i;
            we_q      <= cmd_we_i;
            bstb_q    <= cmd_byte_stb_i;
            wdat_q    <= cmd_dat_i;
            cyc_q     <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= BUS;
          end
        end
        BUS: begin
          if (WBm_ACK_i) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : WBm_DAT_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (tmo_hit_d) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // CYC and STB are always equal, so both come from one register.
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_BYTE_STB_o = bstb_q;
  assign WBm_DAT_o      = wdat_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign err_cnt_o      = err_cnt_q;
  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_wb_master_sequencer.sv
// tb_wb_master_sequencer
// Directed bench for wb_master_sequencer. A small register-block slave model
// answers in one of three ways: a registered one-cycle ACK, no ACK at all, or
// an ACK delayed to the 16th cycle of the bus cycle.
module tb_wb_master_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWe;
  logic [6:0]  cmdAdr;
  logic [3:0]  cmdStb;
  logic [31:0] cmdDat;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspDat;
  logic        rspErr;
  logic [6:0]  wbAdr;
  logic        wbCyc;
  logic        wbStb;
  logic        wbWe;
  logic [3:0]  wbBstb;
  logic [31:0] wbDatO;
  logic [31:0] slvDat;
  logic        slvAck;
  logic        forceAck;
  logic        busy;
  logic [7:0]  errCnt;

  int          assertCount = 0;
  int          failCount = 0;
  int          ackMode = 0;
  int          expErrCnt = 0;

  logic [31:0] mem [128];
  int          cycCnt;
  int          cycTotal = 0;
  int          weTotal = 0;
  int          stbDiffTotal = 0;
  logic [6:0]  obsAdr = '0;
  logic [31:0] obsDat = '0;

  wb_master_sequencer #(
    .ADDRWIDTH(7),
    .DATAWIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .WBs_CLK_i(clk),
    .WBs_RST_n_i(rstN),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_we_i(cmdWe),
    .cmd_adr_i(cmdAdr),
    .cmd_byte_stb_i(cmdStb),
    .cmd_dat_i(cmdDat),
    .rsp_valid_o(rspValid),
    .rsp_ready_i(rspReady),
    .rsp_dat_o(rspDat),
    .rsp_err_o(rspErr),
    .WBm_ADR_o(wbAdr),
    .WBm_CYC_o(wbCyc),
    .WBm_STB_o(wbStb),
    .WBm_WE_o(wbWe),
    .WBm_BYTE_STB_o(wbBstb),
    .WBm_DAT_o(wbDatO),
    .WBm_DAT_i(slvDat),
    .WBm_ACK_i(slvAck | forceAck),
    .busy_o(busy),
    .err_cnt_o(errCnt)
  );

  always #5 clk = ~clk;

  // Slave model: ackMode 0 = registered one-cycle ACK, 1 = never ACK,
  // 2 = ACK during the 16th cycle that CYC is high.
  always @(posedge clk) begin
    if (!rstN) begin
      slvAck <= 1'b0;
      slvDat <= '0;
      cycCnt <= 0;
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000DEEB;
      mem[5] <= 32'h11223344;
      mem[7] <= 32'hCAFEF00D;
    end else begin
      cycCnt <= wbCyc ? cycCnt + 1 : 0;
      slvAck <= 1'b0;
      if (wbCyc && wbStb && !slvAck &&
          (ackMode == 0 || (ackMode == 2 && cycCnt == 14))) begin
        slvAck <= 1'b1;
        if (wbWe) begin
          for (int b = 0; b < 4; b++)
            if (wbBstb[b]) mem[wbAdr][8*b +: 8] <= wbDatO[8*b +: 8];
        end else begin
          slvDat <= mem[wbAdr];
        end
      end
    end
  end

  // Bus monitor: running totals, sampled mid-cycle.
  always @(negedge clk) begin
    if (wbCyc) begin
      cycTotal = cycTotal + 1;
      if (wbWe) weTotal = weTotal + 1;
      obsAdr = wbAdr;
      obsDat = wbDatO;
    end
    if (wbCyc != wbStb) stbDiffTotal = stbDiffTotal + 1;
  end

  typedef struct {
    logic        we;
    logic [6:0]  adr;
    logic [3:0]  stb;
    logic [31:0] dat;
    int          mode;
    logic [31:0] expDat;
    logic        expErr;
    int          expCyc;
  } vec_t;

  vec_t vectors [8];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [6:0] adr,
                               input logic [3:0] stb, input logic [31:0] dat);
    cmdWe    = we;
    cmdAdr   = adr;
    cmdStb   = stb;
    cmdDat   = dat;
    cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitRsp();
    int n = 0;
    while (!rspValid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rspTimely", {31'b0, rspValid}, 32'h1);
  endtask

  task automatic consumeRsp();
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput("rspDropped", {31'b0, rspValid}, 32'h0);
    checkOutput("readyAgain", {31'b0, cmdReady}, 32'h1);
  endtask

  task automatic runVector(input vec_t v);
    int cycStart;
    int weStart;
    ackMode  = v.mode;
    cycStart = cycTotal;
    weStart  = weTotal;
    applyStimulus(v.we, v.adr, v.stb, v.dat);
    waitRsp();
    if (v.expErr) expErrCnt = (expErrCnt < 255) ? expErrCnt + 1 : 255;
    checkOutput("rspErr", {31'b0, rspErr}, {31'b0, v.expErr});
    checkOutput("rspDat", rspDat, v.expDat);
    checkOutput("cycCycles", cycTotal - cycStart, v.expCyc);
    checkOutput("weCycles", weTotal - weStart, v.we ? v.expCyc : 0);
    checkOutput("busAdr", {25'b0, obsAdr}, {25'b0, v.adr});
    checkOutput("busDat", obsDat, v.dat);
    checkOutput("errCnt", {24'b0, errCnt}, expErrCnt);
    consumeRsp();
  endtask

  initial begin
    vectors[0] = '{1'b1, 7'h06, 4'hF, 32'h12345678, 0, 32'h00000000, 1'b0, 2};
    vectors[1] = '{1'b0, 7'h06, 4'hF, 32'h00000000, 0, 32'h12345678, 1'b0, 2};
    vectors[2] = '{1'b0, 7'h00, 4'hF, 32'hFFFFFFFF, 0, 32'h0000DEEB, 1'b0, 2};
    vectors[3] = '{1'b1, 7'h05, 4'h3, 32'hAABBCCDD, 0, 32'h00000000, 1'b0, 2};
    vectors[4] = '{1'b0, 7'h05, 4'hF, 32'h00000000, 0, 32'h1122CCDD, 1'b0, 2};
    vectors[5] = '{1'b0, 7'h1F, 4'hF, 32'h00000000, 1, 32'h00000000, 1'b1, 16};
    vectors[6] = '{1'b0, 7'h07, 4'hF, 32'h00000000, 2, 32'hCAFEF00D, 1'b0, 16};
    vectors[7] = '{1'b1, 7'h1F, 4'hF, 32'h0F0F0F0F, 1, 32'h00000000, 1'b1, 16};

    rstN     = 1'b0;
    cmdValid = 1'b0;
    cmdWe    = 1'b0;
    cmdAdr   = '0;
    cmdStb   = '0;
    cmdDat   = '0;
    rspReady = 1'b0;
    forceAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    // Reset state
    checkOutput("rstCmdReady", {31'b0, cmdReady}, 32'h1);
    checkOutput("rstBusy", {31'b0, busy}, 32'h0);
    checkOutput("rstBus", {wbCyc, wbStb, wbWe, wbBstb, wbAdr}, 32'h0);
    checkOutput("rstWdat", wbDatO, 32'h0);
    checkOutput("rstRsp", {rspValid, rspErr, errCnt}, 32'h0);
    checkOutput("rstRspDat", rspDat, 32'h0);

    for (int i = 0; i < 8; i++) runVector(vectors[i]);

    // A late ACK while in RESP is ignored, and also in IDLE.
    ackMode = 1;
    applyStimulus(1'b0, 7'h1F, 4'hF, 32'h0);
    waitRsp();
    expErrCnt++;
    repeat (3) @(posedge clk);
    #1;
    forceAck = 1'b1;
    @(posedge clk); #1;
    forceAck = 1'b0;
    checkOutput("lateValid", {31'b0, rspValid}, 32'h1);
    checkOutput("lateErr", {31'b0, rspErr}, 32'h1);
    checkOutput("lateDat", rspDat, 32'h0);
    checkOutput("lateState", {busy, cmdReady, wbCyc, wbStb}, 32'h8);
    checkOutput("lateErrCnt", {24'b0, errCnt}, expErrCnt);
    consumeRsp();
    forceAck = 1'b1;
    @(posedge clk); #1;
    forceAck = 1'b0;
    checkOutput("idleAckIgnored", {busy, rspValid, wbCyc}, 32'h0);

    // Response back-pressure with a second command waiting.
    ackMode  = 0;
    cmdWe    = 1'b0;
    cmdAdr   = 7'h00;
    cmdStb   = 4'hF;
    cmdDat   = 32'h0;
    cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdAdr = 7'h06;
    waitRsp();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("holdValid", {31'b0, rspValid}, 32'h1);
      checkOutput("holdDat", rspDat, 32'h0000DEEB);
      checkOutput("holdNoAccept", {cmdReady, wbCyc}, 32'h0);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput("bpIdle", {cmdReady, wbCyc, rspValid}, 32'h4);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    checkOutput("bpAccept", {wbCyc, busy, wbWe}, 32'h6);
    checkOutput("bpAdr", {25'b0, wbAdr}, 32'h06);
    waitRsp();
    checkOutput("bpDat", rspDat, 32'h12345678);
    consumeRsp();

    // Saturate the timeout counter.
    for (int i = 0; i < 256; i++) runVector(vectors[5]);
    checkOutput("errSaturated", {24'b0, errCnt}, 32'hFF);

    // Reset during the second BUS cycle.
    ackMode = 0;
    applyStimulus(1'b1, 7'h0A, 4'hF, 32'h55AA55AA);
    checkOutput("midCyc1", {31'b0, wbCyc}, 32'h1);
    @(posedge clk); #1;
    checkOutput("midCyc2", {31'b0, wbCyc}, 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("asyncCycStb", {wbCyc, wbStb, rspValid}, 32'h0);
    checkOutput("asyncErrCnt", {24'b0, errCnt}, 32'h0);
    checkOutput("asyncState", {busy, cmdReady}, 32'h1);
    @(posedge clk); #1;
    rstN = 1'b1;
    expErrCnt = 0;
    runVector('{1'b1, 7'h0A, 4'hF, 32'h55AA55AA, 0, 32'h0, 1'b0, 2});
    runVector('{1'b0, 7'h0A, 4'hF, 32'h0, 0, 32'h55AA55AA, 1'b0, 2});

    checkOutput("cycEqStb", stbDiffTotal, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
